stage4_memaccess: RTL and testbench

STAGE4_MEMACCESS -- requirements
Module: stage4_memaccess

---
 rtl/stage4_memaccess_pkg.sv | 66 ++++++
 rtl/defines.sv | 4 +
 rtl/stage4_load_align.sv | 16 +
 rtl/stage4_memaccess.sv | 236 +++++++++++++++++++++++
 tb/tb_stage4_memaccess.sv | 508 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/stage4_memaccess_pkg.sv
// Shared LEGv8 memory-stage types: access-size encoding, FSM states and the
// load lane extract/extend helper.
`ifndef LEGV8_INTEGER_SZ
`define LEGV8_INTEGER_SZ 64
`endif

package stage4_memaccess_pkg;

    localparam int unsigned XLEN = `LEGV8_INTEGER_SZ;

    typedef enum logic [1:0] {
        MEM_BYTE  = 2'b00,
        MEM_HALF  = 2'b01,
        MEM_WORD  = 2'b10,
        MEM_DWORD = 2'b11
    } mem_size_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT_RD,
        ST_DONE
    } mem_state_e;

    function automatic logic [7:0] size_be_mask(input mem_size_e size);
        logic [7:0] m;
        case (size)
            MEM_BYTE: m = 8'h01;
            MEM_HALF: m = 8'h03;
            MEM_WORD: m = 8'h0F;
            default:  m = 8'hFF;
        endcase
        return m;
    endfunction

    // Low address bits that must be zero for a naturally aligned access.
    function automatic logic [2:0] align_mask(input mem_size_e size);
        logic [2:0] m;
        case (size)
            MEM_BYTE: m = 3'b000;
            MEM_HALF: m = 3'b001;
            MEM_WORD: m = 3'b011;
            default:  m = 3'b111;
        endcase
        return m;
    endfunction

    function automatic logic [63:0] load_extract(
        input logic [63:0] rdata,
        input logic [2:0]  offset,
        input mem_size_e   size,
        input logic        is_signed
    );
        logic [63:0] lane;
        logic [63:0] res;
        lane = rdata >> {offset, 3'b000};
        case (size)
            MEM_BYTE: res = {{56{is_signed & lane[7]}},  lane[7:0]};
            MEM_HALF: res = {{48{is_signed & lane[15]}}, lane[15:0]};
            MEM_WORD: res = {{32{is_signed & lane[31]}}, lane[31:0]};
            default:  res = lane;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/defines.sv
// LEGv8 width macros shared by the datapath stages.
`ifndef LEGV8_INTEGER_SZ
`define LEGV8_INTEGER_SZ 64
`endif

// File: rtl/stage4_load_align.sv
// Combinational load lane select with zero/sign extension to 64 bits.
module stage4_load_align
    import stage4_memaccess_pkg::*;
(
    input  logic [63:0] rdata,
    input  logic [2:0]  offset,
    input  logic [1:0]  size,
    input  logic        is_signed,
    output logic [63:0] data
);

    always_comb begin
        data = load_extract(rdata, offset, mem_size_e'(size), is_signed);
    end

endmodule

// File: rtl/stage4_memaccess.sv
// LEGv8 pipeline stage 4: data-memory access with valid/ready handshakes on
// both sides and a single-outstanding request/grant/rvalid memory port.
`ifndef LEGV8_INTEGER_SZ
`define LEGV8_INTEGER_SZ 64
`endif

module stage4_memaccess
    import stage4_memaccess_pkg::*;
#(
    parameter int unsigned DATA_W = `LEGV8_INTEGER_SZ
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] exec_result,
    input  logic [DATA_W-1:0] store_data,
    input  logic              memread,
    input  logic              memwrite,
    input  logic              mem_signed,
    input  logic              memtoreg,
    input  logic              regwrite,
    input  logic [1:0]        mem_size,
    input  logic [4:0]        rd,

    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] val_stage3_execute,
    output logic [DATA_W-1:0] val_stage4_memacc,
    output logic              out_memtoreg,
    output logic              out_regwrite,
    output logic [4:0]        out_rd,

    output logic              dmem_req,
    output logic              dmem_we,
    input  logic              dmem_gnt,
    input  logic              dmem_rvalid,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [7:0]        dmem_be,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,

    output logic              misalign_fault
);

    mem_state_e        state_q, state_d;

    logic [DATA_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] exec_q, exec_d;
    logic [7:0]        be_q, be_d;
    logic [2:0]        off_q, off_d;
    mem_size_e         size_q, size_d;
    logic              store_q, store_d;
    logic              signed_q, signed_d;
    logic              memtoreg_q, memtoreg_d;
    logic              regwrite_q, regwrite_d;
    logic [4:0]        rd_q, rd_d;

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] val3_q, val3_d;
    logic [DATA_W-1:0] val4_q, val4_d;
    logic              out_memtoreg_q, out_memtoreg_d;
    logic              out_regwrite_q, out_regwrite_d;
    logic [4:0]        out_rd_q, out_rd_d;
    logic              misalign_q, misalign_d;

    logic [DATA_W-1:0] load_data;
    mem_size_e         in_size;
    logic              accept;
    logic              is_mem;
    logic              misaligned;

    stage4_load_align u_load_align (
        .rdata     (dmem_rdata),
        .offset    (off_q),
        .size      (size_q),
        .is_signed (signed_q),
        .data      (load_data)
    );

    assign in_size    = mem_size_e'(mem_size);
    assign in_ready   = (state_q == ST_IDLE) && (!out_valid_q || out_ready);
    assign accept     = in_valid && in_ready;
    assign is_mem     = memread || memwrite;
    assign misaligned = is_mem && ((exec_result[2:0] & align_mask(in_size)) != 3'b000);

    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        exec_d         = exec_q;
        be_d           = be_q;
        off_d          = off_q;
        size_d         = size_q;
        store_d        = store_q;
        signed_d       = signed_q;
        memtoreg_d     = memtoreg_q;
        regwrite_d     = regwrite_q;
        rd_d           = rd_q;
        out_valid_d    = out_valid_q;
        val3_d         = val3_q;
        val4_d         = val4_q;
        out_memtoreg_d = out_memtoreg_q;
        out_regwrite_d = out_regwrite_q;
        out_rd_d       = out_rd_q;
        misalign_d     = 1'b0;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (!is_mem || misaligned) begin
                        out_valid_d    = 1'b1;
                        val3_d         = exec_result;
                        val4_d         = '0;
                        out_memtoreg_d = memtoreg && !misaligned;
                        out_regwrite_d = regwrite && !misaligned;
                        out_rd_d       = rd;
                        misalign_d     = misaligned;
                    end else begin
                        state_d    = ST_REQ;
                        addr_d     = {exec_result[DATA_W-1:3], 3'b000};
                        be_d       = size_be_mask(in_size) << exec_result[2:0];
                        wdata_d    = store_data << {exec_result[2:0], 3'b000};
                        exec_d     = exec_result;
                        off_d      = exec_result[2:0];
                        size_d     = in_size;
                        store_d    = memwrite;
                        signed_d   = mem_signed;
                        memtoreg_d = memtoreg;
                        regwrite_d = regwrite;
                        rd_d       = rd;
                    end
                end
            end
            // The output slot is always empty here: accepting required it free.
            ST_REQ: begin
                if (dmem_gnt) begin
                    if (store_q) begin
                        state_d        = ST_DONE;
                        out_valid_d    = 1'b1;
                        val3_d         = exec_q;
                        val4_d         = '0;
                        out_memtoreg_d = memtoreg_q;
                        out_regwrite_d = 1'b0;
                        out_rd_d       = rd_q;
                    end else begin
                        state_d = ST_WAIT_RD;
                    end
                end
            end
            ST_WAIT_RD: begin
                if (dmem_rvalid) begin
                    state_d        = ST_DONE;
                    out_valid_d    = 1'b1;
                    val3_d         = exec_q;
                    val4_d         = load_data;
                    out_memtoreg_d = memtoreg_q;
                    out_regwrite_d = regwrite_q;
                    out_rd_d       = rd_q;
                end
            end
            // A stalled result is held by the output register itself, so DONE
            // hands back to IDLE and in_ready tracks the slot from there.
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            addr_q         <= '0;
            wdata_q        <= '0;
            exec_q         <= '0;
            be_q           <= '0;
            off_q          <= '0;
            size_q         <= MEM_BYTE;
            store_q        <= 1'b0;
            signed_q       <= 1'b0;
            memtoreg_q     <= 1'b0;
            regwrite_q     <= 1'b0;
            rd_q           <= '0;
            out_valid_q    <= 1'b0;
            val3_q         <= '0;
            val4_q         <= '0;
            out_memtoreg_q <= 1'b0;
            out_regwrite_q <= 1'b0;
            out_rd_q       <= '0;
            misalign_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            exec_q         <= exec_d;
            be_q           <= be_d;
            off_q          <= off_d;
            size_q         <= size_d;
            store_q        <= store_d;
            signed_q       <= signed_d;
            memtoreg_q     <= memtoreg_d;
            regwrite_q     <= regwrite_d;
            rd_q           <= rd_d;
            out_valid_q    <= out_valid_d;
            val3_q         <= val3_d;
            val4_q         <= val4_d;
            out_memtoreg_q <= out_memtoreg_d;
            out_regwrite_q <= out_regwrite_d;
            out_rd_q       <= out_rd_d;
            misalign_q     <= misalign_d;
        end
    end

    assign dmem_req           = (state_q == ST_REQ);
    assign dmem_we            = (state_q == ST_REQ) && store_q;
    assign dmem_addr          = addr_q;
    assign dmem_be            = be_q;
    assign dmem_wdata         = wdata_q;
    assign out_valid          = out_valid_q;
    assign val_stage3_execute = val3_q;
    assign val_stage4_memacc  = val4_q;
    assign out_memtoreg       = out_memtoreg_q;
    assign out_regwrite       = out_regwrite_q;
    assign out_rd             = out_rd_q;
    assign misalign_fault     = misalign_q;

endmodule

// File: tb/tb_stage4_memaccess.sv
// Scoreboard bench for stage4_memaccess: expected writeback records are queued
// at acceptance and compared as the stage hands them to writeback.
`timescale 1ns/1ps

module tb_stage4_memaccess;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [63:0] exec_result, store_data;
    logic        memread, memwrite, mem_signed, memtoreg, regwrite;
    logic [1:0]  mem_size;
    logic [4:0]  rd;
    logic        out_valid, out_ready;
    logic [63:0] val_stage3_execute, val_stage4_memacc;
    logic        out_memtoreg, out_regwrite;
    logic [4:0]  out_rd;
    logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
    logic [63:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [7:0]  dmem_be;
    logic        misalign_fault;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [63:0] ex;
        logic [63:0] sd;
        logic        mrd;
        logic        mwr;
        logic        sg;
        logic        m2r;
        logic        rw;
        logic [1:0]  sz;
        logic [4:0]  rd;
    } op_t;

    typedef struct {
        logic [63:0] v3;
        logic [63:0] v4;
        logic        m2r;
        logic        rw;
        logic [4:0]  rd;
    } exp_t;

    exp_t sb[$];

    stage4_memaccess #(.DATA_W(64)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .in_valid           (in_valid),
        .in_ready           (in_ready),
        .exec_result        (exec_result),
        .store_data         (store_data),
        .memread            (memread),
        .memwrite           (memwrite),
        .mem_signed         (mem_signed),
        .memtoreg           (memtoreg),
        .regwrite           (regwrite),
        .mem_size           (mem_size),
        .rd                 (rd),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
        .val_stage3_execute (val_stage3_execute),
        .val_stage4_memacc  (val_stage4_memacc),
        .out_memtoreg       (out_memtoreg),
        .out_regwrite       (out_regwrite),
        .out_rd             (out_rd),
        .dmem_req           (dmem_req),
        .dmem_we            (dmem_we),
        .dmem_gnt           (dmem_gnt),
        .dmem_rvalid        (dmem_rvalid),
        .dmem_addr          (dmem_addr),
        .dmem_be            (dmem_be),
        .dmem_wdata         (dmem_wdata),
        .dmem_rdata         (dmem_rdata),
        .misalign_fault     (misalign_fault)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_op(input op_t o);
        exec_result = o.ex;
        store_data  = o.sd;
        memread     = o.mrd;
        memwrite    = o.mwr;
        mem_signed  = o.sg;
        memtoreg    = o.m2r;
        regwrite    = o.rw;
        mem_size    = o.sz;
        rd          = o.rd;
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input op_t o, input exp_t e, input bit push, output int waited);
        int n;
        apply_op(o);
        in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        waited = n;
        checks++;
        if (!in_ready) begin
            failures++;
            $display("FAIL accept_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, n);
        end
        if (push) sb.push_back(e);
        step();
        in_valid = 1'b0;
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL sb_unexpected: output val3=%h with no expected entry", val_stage3_execute);
                end else begin
                    e = sb.pop_front();
                    if (val_stage3_execute !== e.v3 || val_stage4_memacc !== e.v4 ||
                        out_memtoreg !== e.m2r || out_regwrite !== e.rw || out_rd !== e.rd) begin
                        failures++;
                        $display("FAIL sb_output: got v3=%h v4=%h m2r=%0b rw=%0b rd=%0d, required v3=%h v4=%h m2r=%0b rw=%0b rd=%0d",
                                 val_stage3_execute, val_stage4_memacc, out_memtoreg, out_regwrite, out_rd,
                                 e.v3, e.v4, e.m2r, e.rw, e.rd);
                    end
                end
            end
        end
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL %s_drain: %0d results outstanding, required 0", name, sb.size());
        end
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || dmem_req !== 1'b0 || dmem_we !== 1'b0 || misalign_fault !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl: ov=%0b req=%0b we=%0b mis=%0b, required all 0",
                     out_valid, dmem_req, dmem_we, misalign_fault);
        end
        checks++;
        if (out_regwrite !== 1'b0 || out_memtoreg !== 1'b0 || out_rd !== 5'd0) begin
            failures++;
            $display("FAIL reset_wb: rw=%0b m2r=%0b rd=%0d, required 0", out_regwrite, out_memtoreg, out_rd);
        end
        checks++;
        if (dmem_addr !== 64'd0 || dmem_be !== 8'd0 || dmem_wdata !== 64'd0) begin
            failures++;
            $display("FAIL reset_dmem: addr=%h be=%h wdata=%h, required 0", dmem_addr, dmem_be, dmem_wdata);
        end
        checks++;
        if (val_stage3_execute !== 64'd0 || val_stage4_memacc !== 64'd0) begin
            failures++;
            $display("FAIL reset_vals: v3=%h v4=%h, required 0", val_stage3_execute, val_stage4_memacc);
        end
        step();
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready: got %0b, required 1", in_ready);
        end
        step();
    endtask

    task automatic test_alu();
        op_t o;
        exp_t e;
        int w;
        out_ready = 1'b1;
        o = '{ex: 64'h1234, sd: 64'd0, mrd: 1'b0, mwr: 1'b0, sg: 1'b0, m2r: 1'b0, rw: 1'b1, sz: 2'b11, rd: 5'd3};
        e = '{v3: 64'h1234, v4: 64'd0, m2r: 1'b0, rw: 1'b1, rd: 5'd3};
        send(o, e, 1'b1, w);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || dmem_req !== 1'b0) begin
            failures++;
            $display("FAIL alu_latency: ov=%0b req=%0b, required ov=1 req=0", out_valid, dmem_req);
        end
        step();
        wait_drain("alu");
    endtask

    task automatic test_back_to_back();
        op_t o;
        exp_t e;
        int w;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            o.ex  = {$urandom, $urandom};
            o.sd  = 64'd0;
            o.mrd = 1'b0;
            o.mwr = 1'b0;
            o.sg  = 1'b0;
            o.m2r = 1'($urandom_range(0, 1));
            o.rw  = 1'($urandom_range(0, 1));
            o.sz  = 2'($urandom_range(0, 3));
            o.rd  = 5'(i + 10);
            e = '{v3: o.ex, v4: 64'd0, m2r: o.m2r, rw: o.rw, rd: o.rd};
            send(o, e, 1'b1, w);
            if (i > 0) begin
                checks++;
                if (w != 0) begin
                    failures++;
                    $display("FAIL b2b_bubble: op %0d waited %0d cycles, required 0", i, w);
                end
            end
        end
        wait_drain("b2b");
    endtask

    task automatic test_load_signed();
        op_t o;
        exp_t e;
        int w;
        out_ready = 1'b1;
        o = '{ex: 64'h103, sd: 64'd0, mrd: 1'b1, mwr: 1'b0, sg: 1'b1, m2r: 1'b1, rw: 1'b1, sz: 2'b00, rd: 5'd5};
        e = '{v3: 64'h103, v4: 64'hFFFF_FFFF_FFFF_FF80, m2r: 1'b1, rw: 1'b1, rd: 5'd5};
        send(o, e, 1'b1, w);
        @(negedge clk);
        checks++;
        if (dmem_req !== 1'b1 || dmem_we !== 1'b0 || dmem_addr !== 64'h100 || dmem_be !== 8'h08) begin
            failures++;
            $display("FAIL ldurb_req: req=%0b we=%0b addr=%h be=%h, required 1 0 100 08",
                     dmem_req, dmem_we, dmem_addr, dmem_be);
        end
        step();
        @(negedge clk);
        checks++;
        if (dmem_req !== 1'b1 || dmem_addr !== 64'h100 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL ldurb_hold: req=%0b addr=%h ov=%0b, required 1 100 0", dmem_req, dmem_addr, out_valid);
        end
        step();
        dmem_gnt    = 1'b1;
        dmem_rvalid = 1'b1;
        dmem_rdata  = '1;
        step();
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
        @(negedge clk);
        checks++;
        if (dmem_req !== 1'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL ldurb_gnt_rvalid: req=%0b ov=%0b, required 0 0", dmem_req, out_valid);
        end
        step();
        dmem_rvalid = 1'b1;
        dmem_rdata  = 64'h0000_0000_8000_0000;
        step();
        dmem_rvalid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1) begin
            failures++;
            $display("FAIL ldurb_done: ov=%0b, required 1", out_valid);
        end
        step();
        wait_drain("ldurb");
    endtask

    task automatic test_store();
        op_t o;
        exp_t e;
        int w;
        logic [63:0] sd;
        out_ready = 1'b1;
        o = '{ex: 64'h206, sd: 64'h1234_5678_9ABC_BEEF, mrd: 1'b0, mwr: 1'b1, sg: 1'b0, m2r: 1'b0, rw: 1'b1, sz: 2'b01, rd: 5'd7};
        e = '{v3: 64'h206, v4: 64'd0, m2r: 1'b0, rw: 1'b0, rd: 5'd7};
        send(o, e, 1'b1, w);
        @(negedge clk);
        checks++;
        if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_addr !== 64'h200 ||
            dmem_be !== 8'hC0 || dmem_wdata !== 64'hBEEF_0000_0000_0000) begin
            failures++;
            $display("FAIL sturh_req: req=%0b we=%0b addr=%h be=%h wdata=%h, required 1 1 200 c0 beef000000000000",
                     dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata);
        end
        step();
        dmem_gnt = 1'b1;
        step();
        dmem_gnt = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || dmem_req !== 1'b0) begin
            failures++;
            $display("FAIL sturh_done: ov=%0b req=%0b, required 1 0", out_valid, dmem_req);
        end
        step();
        wait_drain("sturh");

        sd = {$urandom, $urandom};
        o = '{ex: 64'h18, sd: sd, mrd: 1'b1, mwr: 1'b1, sg: 1'b0, m2r: 1'b1, rw: 1'b1, sz: 2'b11, rd: 5'd8};
        e = '{v3: 64'h18, v4: 64'd0, m2r: 1'b1, rw: 1'b0, rd: 5'd8};
        send(o, e, 1'b1, w);
        @(negedge clk);
        checks++;
        if (dmem_we !== 1'b1 || dmem_be !== 8'hFF || dmem_wdata !== sd || dmem_addr !== 64'h18) begin
            failures++;
            $display("FAIL rdwr_as_store: we=%0b be=%h wdata=%h addr=%h, required 1 ff %h 18",
                     dmem_we, dmem_be, dmem_wdata, dmem_addr, sd);
        end
        step();
        dmem_gnt = 1'b1;
        step();
        dmem_gnt = 1'b0;
        wait_drain("rdwr");
    endtask

    task automatic test_misalign();
        op_t o;
        exp_t e;
        int w;
        out_ready = 1'b1;
        o = '{ex: 64'h104, sd: 64'd0, mrd: 1'b1, mwr: 1'b0, sg: 1'b0, m2r: 1'b1, rw: 1'b1, sz: 2'b11, rd: 5'd9};
        e = '{v3: 64'h104, v4: 64'd0, m2r: 1'b0, rw: 1'b0, rd: 5'd9};
        send(o, e, 1'b1, w);
        @(negedge clk);
        checks++;
        if (misalign_fault !== 1'b1 || dmem_req !== 1'b0 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL ldur_misalign: mis=%0b req=%0b ov=%0b, required 1 0 1", misalign_fault, dmem_req, out_valid);
        end
        step();
        @(negedge clk);
        checks++;
        if (misalign_fault !== 1'b0 || dmem_req !== 1'b0) begin
            failures++;
            $display("FAIL misalign_pulse: mis=%0b req=%0b, required 0 0", misalign_fault, dmem_req);
        end
        step();
        o = '{ex: 64'h31, sd: 64'hAA, mrd: 1'b0, mwr: 1'b1, sg: 1'b0, m2r: 1'b0, rw: 1'b0, sz: 2'b01, rd: 5'd2};
        e = '{v3: 64'h31, v4: 64'd0, m2r: 1'b0, rw: 1'b0, rd: 5'd2};
        send(o, e, 1'b1, w);
        @(negedge clk);
        checks++;
        if (misalign_fault !== 1'b1 || dmem_req !== 1'b0) begin
            failures++;
            $display("FAIL sturh_misalign: mis=%0b req=%0b, required 1 0", misalign_fault, dmem_req);
        end
        step();
        wait_drain("misalign");
    endtask

    task automatic test_backpressure();
        op_t o;
        exp_t e;
        int w;
        logic [63:0] r;
        logic [63:0] nx;
        r  = {$urandom, $urandom};
        nx = {$urandom, $urandom};
        out_ready = 1'b0;
        o = '{ex: 64'h40, sd: 64'd0, mrd: 1'b1, mwr: 1'b0, sg: 1'b1, m2r: 1'b1, rw: 1'b1, sz: 2'b11, rd: 5'd4};
        e = '{v3: 64'h40, v4: r, m2r: 1'b1, rw: 1'b1, rd: 5'd4};
        send(o, e, 1'b1, w);
        dmem_gnt = 1'b1;
        step();
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b1;
        dmem_rdata  = r;
        step();
        dmem_rvalid = 1'b0;
        dmem_rdata  = '0;
        o = '{ex: nx, sd: 64'd0, mrd: 1'b0, mwr: 1'b0, sg: 1'b0, m2r: 1'b0, rw: 1'b1, sz: 2'b00, rd: 5'd6};
        apply_op(o);
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || val_stage4_memacc !== r || val_stage3_execute !== 64'h40 || in_ready !== 1'b0) begin
                failures++;
                $display("FAIL stall_hold[%0d]: ov=%0b v4=%h v3=%h in_ready=%0b, required 1 %h 40 0",
                         i, out_valid, val_stage4_memacc, val_stage3_execute, in_ready, r);
            end
            step();
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL release_accept: in_ready=%0b, required 1", in_ready);
        end
        sb.push_back('{v3: nx, v4: 64'd0, m2r: 1'b0, rw: 1'b1, rd: 5'd6});
        step();
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || val_stage3_execute !== nx) begin
            failures++;
            $display("FAIL release_next: ov=%0b v3=%h, required 1 %h", out_valid, val_stage3_execute, nx);
        end
        step();
        wait_drain("stall");
    endtask

    task automatic test_reset_midflight();
        op_t o;
        exp_t e;
        int w;
        out_ready = 1'b1;
        o = '{ex: 64'h80, sd: 64'd0, mrd: 1'b1, mwr: 1'b0, sg: 1'b0, m2r: 1'b1, rw: 1'b1, sz: 2'b11, rd: 5'd12};
        e = '{v3: 64'h80, v4: 64'd0, m2r: 1'b1, rw: 1'b1, rd: 5'd12};
        send(o, e, 1'b0, w);
        dmem_gnt = 1'b1;
        step();
        dmem_gnt = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        checks++;
        if (out_valid !== 1'b0 || dmem_req !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL midreset_state: ov=%0b req=%0b in_ready=%0b, required 0 0 1", out_valid, dmem_req, in_ready);
        end
        step();
        rst_n       = 1'b1;
        dmem_rvalid = 1'b1;
        dmem_rdata  = {$urandom, $urandom};
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0 || dmem_req !== 1'b0) begin
                failures++;
                $display("FAIL midreset_rvalid[%0d]: ov=%0b req=%0b, required 0 0", i, out_valid, dmem_req);
            end
            step();
        end
        dmem_rvalid = 1'b0;
        o = '{ex: 64'h55, sd: 64'd0, mrd: 1'b0, mwr: 1'b0, sg: 1'b0, m2r: 1'b0, rw: 1'b1, sz: 2'b00, rd: 5'd1};
        e = '{v3: 64'h55, v4: 64'd0, m2r: 1'b0, rw: 1'b1, rd: 5'd1};
        send(o, e, 1'b1, w);
        wait_drain("post_reset");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        in_valid    = 1'b0;
        exec_result = '0;
        store_data  = '0;
        memread     = 1'b0;
        memwrite    = 1'b0;
        mem_signed  = 1'b0;
        memtoreg    = 1'b0;
        regwrite    = 1'b0;
        mem_size    = 2'b00;
        rd          = '0;
        out_ready   = 1'b1;
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
        dmem_rdata  = '0;
        rst_n       = 1'b0;
        fork
            monitor();
        join_none
        test_reset();
        test_alu();
        test_back_to_back();
        test_load_signed();
        test_store();
        test_misalign();
        test_backpressure();
        test_reset_midflight();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL sb_leftover: %0d entries, required 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
